// File: rtl/piezo_pkg.sv
// Shared types and the default alert pattern table for the piezo alert sequencer.
package piezo_pkg;

    typedef struct packed {
        logic [15:0] half_per;
        logic [11:0] on_ms;
        logic [11:0] off_ms;
        logic [3:0]  beeps;
        logic [11:0] rest_ms;
    } alert_pat_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEEP = 2'd1,
        GAP  = 2'd2,
        REST = 2'd3
    } state_t;

    // Index 0 (overspeed) is the highest-priority channel.
    localparam alert_pat_t [2:0] PAT_DEFAULT = {
        alert_pat_t'{half_per: 16'd25000, on_ms: 12'd150, off_ms: 12'd0,   beeps: 4'd1, rest_ms: 12'd1850},
        alert_pat_t'{half_per: 16'd12500, on_ms: 12'd100, off_ms: 12'd100, beeps: 4'd2, rest_ms: 12'd1600},
        alert_pat_t'{half_per: 16'd6250,  on_ms: 12'd100, off_ms: 12'd100, beeps: 4'd1, rest_ms: 12'd0}
    };

endpackage

// File: rtl/piezo_tone.sv
// Square-wave tone generator; the wave restarts high on each rising edge of i_en.
module piezo_tone (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic [15:0] i_halfPer,
    output logic        o_wave
);

    logic [15:0] r_cnt;
    logic        r_phase;

    // Held cleared and high while disabled, so the first enabled cycle is a high half-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 16'd0;
            r_phase <= 1'b1;
        end else if (!i_en) begin
            r_cnt   <= 16'd0;
            r_phase <= 1'b1;
        end else if (r_cnt >= i_halfPer - 16'd1) begin
            r_cnt   <= 16'd0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 16'd1;
        end
    end

    assign o_wave = r_phase;

endmodule

// File: rtl/piezo_seq.sv
// Priority-arbitrated alert sequencer driving the differential piezo pair.
module piezo_seq
    import piezo_pkg::*;
#(
    parameter int                      NUM_CH   = 3,
    parameter int                      TICK_DIV = 50000,
    parameter alert_pat_t [NUM_CH-1:0] PAT      = PAT_DEFAULT,
    localparam int                     CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] alert_req,
    input  logic              mute,
    output logic              sound,
    output logic              sound_n,
    output logic              busy,
    output logic [CH_W-1:0]   active_ch
);

    localparam int PRE_W = $clog2(TICK_DIV);

    if (TICK_DIV < 2) begin : g_badTick
        $error("piezo_seq: TICK_DIV must be at least 2");
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_patCheck
        if (PAT[g].on_ms == 12'd0 || PAT[g].half_per == 16'd0) begin : g_badPat
            $error("piezo_seq: channel %0d has on_ms or half_per of zero", g);
        end
    end

    state_t           r_state;
    logic [CH_W-1:0]  r_activeCh;
    logic [3:0]       r_beepCnt;
    logic [PRE_W-1:0] r_pre;
    logic [11:0]      r_ms;

    alert_pat_t       w_pat;
    logic [3:0]       w_beeps;
    logic [11:0]      w_dur;
    logic             w_timeUp;
    logic             w_reqHeld;
    logic             w_restart;
    logic             w_toneEn;
    logic             w_wave;
    logic             w_soundNext;
    logic [CH_W-1:0]  w_winner;
    state_t           w_nextState;
    logic [CH_W-1:0]  w_nextCh;
    logic [3:0]       w_nextBeepCnt;

    assign w_pat     = PAT[r_activeCh];
    assign w_beeps   = (w_pat.beeps == 4'd0) ? 4'd1 : w_pat.beeps;
    assign w_reqHeld = alert_req[r_activeCh];

    always_comb begin
        w_winner = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (alert_req[i]) w_winner = CH_W'(i);
        end
    end

    always_comb begin
        w_dur = 12'd0;
        case (r_state)
            BEEP:    w_dur = w_pat.on_ms;
            GAP:     w_dur = w_pat.off_ms;
            REST:    w_dur = w_pat.rest_ms;
            default: w_dur = 12'd0;
        endcase
    end

    // Last cycle of a timed state: both timers sit at their terminal values.
    assign w_timeUp = (r_state != IDLE) && (r_ms == w_dur - 12'd1)
                      && (r_pre == PRE_W'(TICK_DIV - 1));

    // Arbitration only in IDLE and at burst end; a dropped request is the sole early exit.
    always_comb begin
        w_nextState   = r_state;
        w_nextCh      = r_activeCh;
        w_nextBeepCnt = r_beepCnt;
        case (r_state)
            IDLE: begin
                if (|alert_req) begin
                    w_nextState   = BEEP;
                    w_nextCh      = w_winner;
                    w_nextBeepCnt = 4'd1;
                end
            end
            BEEP: begin
                if (w_timeUp) begin
                    if (!w_reqHeld) begin
                        w_nextState = IDLE;
                    end else if (r_beepCnt < w_beeps) begin
                        w_nextBeepCnt = r_beepCnt + 4'd1;
                        w_nextState   = (w_pat.off_ms == 12'd0) ? BEEP : GAP;
                    end else if (w_pat.rest_ms == 12'd0) begin
                        w_nextState   = BEEP;
                        w_nextCh      = w_winner;
                        w_nextBeepCnt = 4'd1;
                    end else begin
                        w_nextState = REST;
                    end
                end
            end
            GAP: begin
                if (!w_reqHeld)    w_nextState = IDLE;
                else if (w_timeUp) w_nextState = BEEP;
            end
            REST: begin
                if (!w_reqHeld) begin
                    w_nextState = IDLE;
                end else if (w_timeUp) begin
                    w_nextState   = BEEP;
                    w_nextCh      = w_winner;
                    w_nextBeepCnt = 4'd1;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_activeCh <= '0;
            r_beepCnt  <= 4'd0;
        end else begin
            r_state    <= w_nextState;
            r_activeCh <= w_nextCh;
            r_beepCnt  <= w_nextBeepCnt;
        end
    end

    // Timers restart on every transition, including BEEP re-entering BEEP.
    assign w_restart = w_timeUp || (w_nextState != r_state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_ms  <= 12'd0;
        end else if (w_restart || r_state == IDLE) begin
            r_pre <= '0;
            r_ms  <= 12'd0;
        end else if (r_pre == PRE_W'(TICK_DIV - 1)) begin
            r_pre <= '0;
            if (r_ms != 12'hFFF) r_ms <= r_ms + 12'd1;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Dropping enable on the final BEEP cycle restarts the tone high on the next BEEP entry.
    assign w_toneEn = (r_state == BEEP) && !w_timeUp;

    piezo_tone u_tone (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (w_toneEn),
        .i_halfPer (w_pat.half_per),
        .o_wave    (w_wave)
    );

    assign w_soundNext = (r_state == BEEP) && w_wave && !mute;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sound   <= 1'b0;
            sound_n <= 1'b1;
        end else begin
            sound   <= w_soundNext;
            sound_n <= ~w_soundNext;
        end
    end

    assign busy      = (r_state != IDLE);
    assign active_ch = r_activeCh;

endmodule

// File: tb/tb_piezo_seq.sv
// Randomized scoreboard bench for piezo_seq against a segment-duration reference model.
module tb_piezo_seq;
    import piezo_pkg::*;

    localparam int TD = 10;

    localparam alert_pat_t [2:0] TEST_PAT = {
        alert_pat_t'{half_per: 16'd2, on_ms: 12'd2, off_ms: 12'd0, beeps: 4'd1, rest_ms: 12'd0},
        alert_pat_t'{half_per: 16'd8, on_ms: 12'd5, off_ms: 12'd4, beeps: 4'd2, rest_ms: 12'd6},
        alert_pat_t'{half_per: 16'd4, on_ms: 12'd3, off_ms: 12'd2, beeps: 4'd1, rest_ms: 12'd0}
    };

    localparam int M_HALF[3]  = '{4, 8, 2};
    localparam int M_ON[3]    = '{3, 5, 2};
    localparam int M_OFF[3]   = '{2, 4, 0};
    localparam int M_BEEPS[3] = '{1, 2, 1};
    localparam int M_REST[3]  = '{0, 6, 0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       mute = 1'b0;
    logic [2:0] alert_req = 3'b000;
    logic       sound;
    logic       sound_n;
    logic       busy;
    logic [1:0] active_ch;

    piezo_seq #(
        .NUM_CH   (3),
        .TICK_DIV (TD),
        .PAT      (TEST_PAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alert_req (alert_req),
        .mute      (mute),
        .sound     (sound),
        .sound_n   (sound_n),
        .busy      (busy),
        .active_ch (active_ch)
    );

    always #5 clk = ~clk;

    int cycCnt = 0;
    always @(posedge clk) cycCnt <= cycCnt + 1;

    typedef enum {S_IDLE, S_BEEP, S_GAP, S_REST} seg_t;
    typedef struct {
        int cyc;
        bit snd;
        bit bsy;
        int ch;
    } exp_t;

    exp_t expQ[$];
    seg_t mSeg = S_IDLE;
    int   mCh = 0;
    int   mBeepNo = 0;
    int   mLeft = 0;
    int   mK = 0;
    int   nChecks = 0;
    int   nErrors = 0;

    task automatic check(string name, int got, int want);
        nChecks++;
        if (got != want) begin
            nErrors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycCnt, got, want);
        end
    endtask

    function automatic int lowestReq(logic [2:0] r);
        for (int i = 0; i < 3; i++) if (r[i]) return i;
        return 0;
    endfunction

    task automatic modelReset();
        mSeg = S_IDLE; mCh = 0; mBeepNo = 0; mLeft = 0; mK = 0;
    endtask

    task automatic startBeep();
        mSeg = S_BEEP; mLeft = M_ON[mCh] * TD; mK = 0;
    endtask

    task automatic startBurst(int ch);
        mCh = ch; mBeepNo = 1; startBeep();
    endtask

    // Advance one cycle with this cycle's inputs; queue the outputs expected next cycle.
    task automatic stepModel(logic [2:0] req, logic mt);
        exp_t e;
        bit   snd;
        int   nBeeps;
        snd = (mSeg == S_BEEP) && (((mK / M_HALF[mCh]) % 2) == 0) && !mt;
        nBeeps = (M_BEEPS[mCh] == 0) ? 1 : M_BEEPS[mCh];
        case (mSeg)
            S_IDLE: if (req != 3'b000) startBurst(lowestReq(req));
            S_BEEP: begin
                mK++; mLeft--;
                if (mLeft == 0) begin
                    if (!req[mCh]) mSeg = S_IDLE;
                    else if (mBeepNo < nBeeps) begin
                        mBeepNo++;
                        if (M_OFF[mCh] == 0) startBeep();
                        else begin mSeg = S_GAP; mLeft = M_OFF[mCh] * TD; end
                    end
                    else if (M_REST[mCh] == 0) startBurst(lowestReq(req));
                    else begin mSeg = S_REST; mLeft = M_REST[mCh] * TD; end
                end
            end
            S_GAP: begin
                if (!req[mCh]) mSeg = S_IDLE;
                else begin mLeft--; if (mLeft == 0) startBeep(); end
            end
            S_REST: begin
                if (!req[mCh]) mSeg = S_IDLE;
                else begin mLeft--; if (mLeft == 0) startBurst(lowestReq(req)); end
            end
            default: mSeg = S_IDLE;
        endcase
        e.cyc = cycCnt + 1;
        e.snd = snd;
        e.bsy = (mSeg != S_IDLE);
        e.ch  = mCh;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(logic [2:0] req, logic mt, int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            alert_req = req;
            mute      = mt;
            stepModel(req, mt);
        end
    endtask

    task automatic checkOutput(exp_t e);
        check("sound", sound, e.snd);
        check("sound_n", sound_n, !e.snd);
        check("busy", busy, e.bsy);
        if (e.bsy) check("active_ch", active_ch, e.ch);
    endtask

    task automatic resetMidCycle(int hold);
        @(posedge clk);
        #3;
        expQ.delete();
        rst_n = 1'b0;
        #1;
        check("rst_async_sound", sound, 0);
        check("rst_async_sound_n", sound_n, 1);
        check("rst_async_busy", busy, 0);
        check("rst_async_active_ch", active_ch, 0);
        repeat (hold) begin
            @(negedge clk);
            check("rst_hold_sound", sound, 0);
            check("rst_hold_busy", busy, 0);
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        alert_req = 3'b000;
        mute      = 1'b0;
        modelReset();
        stepModel(3'b000, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && expQ.size() > 0) begin
            if (expQ[0].cyc == cycCnt) begin
                e = expQ.pop_front();
                checkOutput(e);
            end else if (expQ[0].cyc < cycCnt) begin
                e = expQ.pop_front();
                check("scoreboard_stale", e.cyc, cycCnt);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] r;
        resetMidCycle(3);

        applyStimulus(3'b010, 1'b0, 400);
        applyStimulus(3'b000, 1'b0, 60);

        applyStimulus(3'b010, 1'b0, 20);
        applyStimulus(3'b011, 1'b0, 300);
        applyStimulus(3'b000, 1'b0, 80);

        applyStimulus(3'b010, 1'b0, 60);
        applyStimulus(3'b000, 1'b0, 10);

        applyStimulus(3'b010, 1'b0, 20);
        applyStimulus(3'b000, 1'b0, 60);

        applyStimulus(3'b100, 1'b0, 100);
        applyStimulus(3'b000, 1'b0, 30);

        applyStimulus(3'b001, 1'b0, 10);
        applyStimulus(3'b001, 1'b1, 10);
        applyStimulus(3'b001, 1'b0, 40);
        applyStimulus(3'b000, 1'b0, 40);

        applyStimulus(3'b010, 1'b0, 20);
        resetMidCycle(2);
        applyStimulus(3'b000, 1'b0, 5);

        for (int p = 0; p < 40; p++) begin
            r = 3'($urandom_range(0, 7));
            applyStimulus(r, ($urandom_range(0, 4) == 0), $urandom_range(1, 150));
            if (p == 20) resetMidCycle(2);
        end

        applyStimulus(3'b000, 1'b0, 120);
        repeat (2) @(negedge clk);
        #1;
        check("queue_drained", expQ.size(), 0);
        check("final_busy", busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
